instr_data_mem_arbiter: RTL and testbench

INSTR_DATA_MEM_ARBITER -- requirements
Module: instr_data_mem_arbiter

---
 rtl/instr_data_mem_arbiter_if.sv | 48 ++++
 rtl/instr_data_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_instr_data_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_data_mem_arbiter_if.sv
// Shared bus bundle for the instruction/data memory arbiter: core fetch port,
// core load/store port and the single downstream memory port.
interface instr_data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  instr_req_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [ADDR_W-1:0]     instr_addr_i;
    logic [DATA_W-1:0]     instr_rdata_o;

    logic                  data_req_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic                  data_we_i;
    logic [DATA_W/8-1:0]   data_be_i;
    logic [ADDR_W-1:0]     data_addr_i;
    logic [DATA_W-1:0]     data_wdata_i;
    logic [DATA_W-1:0]     data_rdata_o;

    logic                  mem_req_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic                  mem_we_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/instr_data_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the
// instruction fetch and load/store ports, with in-order response routing.
module instr_data_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    instr_data_mem_arbiter_if.slave    bus,
    output logic [2:0]                 outstanding_o,
    output logic                       spurious_rvalid_o
);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUT);
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUT - 1);

    src_e               id_q [4];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         count;
    src_e               last_grant;
    src_e               lock_src;
    logic               lock_q;
    logic               spurious;

    src_e               sel;
    src_e               head;
    logic               full;
    logic               empty;
    logic               mem_req;
    logic               handshake;
    logic               rvalid_ok;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    logic [DATA_W/8-1:0] be_sel;
    logic               we_sel;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    // A stalled request keeps its owner until it is granted or withdrawn.
    always_comb begin
        sel = SRC_INSTR;
        if (lock_q && ((lock_src == SRC_INSTR && bus.instr_req_i) ||
                       (lock_src == SRC_DATA  && bus.data_req_i)))
            sel = lock_src;
        else if (bus.instr_req_i && bus.data_req_i)
            sel = (last_grant == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        else if (bus.data_req_i)
            sel = SRC_DATA;
    end

    always_comb begin
        addr_sel  = bus.instr_addr_i;
        wdata_sel = '0;
        be_sel    = '1;
        we_sel    = 1'b0;
        if (sel == SRC_DATA) begin
            addr_sel  = bus.data_addr_i;
            wdata_sel = bus.data_wdata_i;
            be_sel    = bus.data_be_i;
            we_sel    = bus.data_we_i;
        end
    end

    assign full      = (count == MAX_CNT);
    assign empty     = (count == 3'd0);
    assign head      = id_q[rd_ptr];
    assign mem_req   = (bus.instr_req_i | bus.data_req_i) & ~full & ~rst_i;
    assign handshake = mem_req & bus.mem_gnt_i;
    // Responses with nothing in flight are dropped rather than routed.
    assign rvalid_ok = bus.mem_rvalid_i & ~empty & ~rst_i;

    assign bus.mem_req_o      = mem_req;
    assign bus.mem_addr_o     = addr_sel;
    assign bus.mem_wdata_o    = wdata_sel;
    assign bus.mem_be_o       = be_sel;
    assign bus.mem_we_o       = we_sel;
    assign bus.instr_gnt_o    = handshake & (sel == SRC_INSTR);
    assign bus.data_gnt_o     = handshake & (sel == SRC_DATA);
    assign bus.instr_rvalid_o = rvalid_ok & (head == SRC_INSTR);
    assign bus.data_rvalid_o  = rvalid_ok & (head == SRC_DATA);
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;

    assign outstanding_o     = count;
    assign spurious_rvalid_o = spurious;

    always_ff @(posedge clk_i) begin
        if (handshake)
            id_q[wr_ptr] <= sel;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= SRC_INSTR;
            lock_src   <= SRC_INSTR;
            lock_q     <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr     <= ptr_next(wr_ptr);
                last_grant <= sel;
            end
            if (rvalid_ok)
                rd_ptr <= ptr_next(rd_ptr);
            if (handshake && !rvalid_ok)
                count <= count + 3'd1;
            else if (!handshake && rvalid_ok)
                count <= count - 3'd1;
            lock_q   <= mem_req & ~bus.mem_gnt_i;
            lock_src <= sel;
            if (bus.mem_rvalid_i && empty)
                spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_data_mem_arbiter.sv
// Scoreboard bench for instr_data_mem_arbiter: directed scenarios plus random
// traffic, checked against a queue-based reference model of the arbitration rules.
module tb_instr_data_mem_arbiter;

    localparam int MAX_OUT = 2;

    typedef struct {
        bit          rst;
        bit          ireq;
        logic [31:0] iaddr;
        bit          dreq;
        bit          dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        bit          mgnt;
        bit          mrv;
        logic [31:0] mrdata;
    } stim_t;

    typedef struct {
        bit          mem_req;
        bit          igt;
        bit          dgt;
        bit          irv;
        bit          drv;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          outst;
        bit          spur;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] outstanding;
    logic       spurious;

    instr_data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_data_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bus              (bus),
        .outstanding_o    (outstanding),
        .spurious_rvalid_o(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Reference model state: 0 = instr, 1 = data.
    bit   pend[$];
    bit   last_g;
    bit   lock_v;
    bit   lock_s;
    bit   spur_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst    = 1'b0;
        s.ireq   = 1'b0;
        s.iaddr  = $urandom;
        s.dreq   = 1'b0;
        s.dwe    = 1'b0;
        s.dbe    = 4'($urandom);
        s.daddr  = $urandom;
        s.dwdata = $urandom;
        s.mgnt   = 1'b0;
        s.mrv    = 1'b0;
        s.mrdata = $urandom;
        return s;
    endfunction

    function automatic exp_t model_eval(input stim_t s);
        exp_t e;
        bit   sel;
        bit   mreq;
        bit   hs;
        bit   rv;
        e.rdata = s.mrdata;
        e.outst = pend.size();
        e.spur  = spur_m;
        e.addr  = '0; e.we = 1'b0; e.be = '0; e.wdata = '0;
        if (s.rst) begin
            e.mem_req = 0; e.igt = 0; e.dgt = 0; e.irv = 0; e.drv = 0;
            pend.delete();
            last_g = 0; lock_v = 0; lock_s = 0; spur_m = 0;
            return e;
        end
        if (lock_v && (lock_s ? s.dreq : s.ireq)) sel = lock_s;
        else if (s.ireq && s.dreq)                sel = !last_g;
        else                                      sel = s.dreq;
        mreq      = (s.ireq || s.dreq) && (pend.size() < MAX_OUT);
        hs        = mreq && s.mgnt;
        rv        = s.mrv && (pend.size() > 0);
        e.mem_req = mreq;
        e.igt     = hs && !sel;
        e.dgt     = hs && sel;
        e.irv     = rv && (pend[0] == 1'b0);
        e.drv     = rv && (pend[0] == 1'b1);
        e.addr    = sel ? s.daddr : s.iaddr;
        e.we      = sel && s.dwe;
        e.be      = sel ? s.dbe : 4'hF;
        e.wdata   = sel ? s.dwdata : 32'h0;
        if (s.mrv && pend.size() == 0) spur_m = 1;
        if (rv) void'(pend.pop_front());
        if (hs) begin
            pend.push_back(sel);
            last_g = sel;
        end
        lock_v = mreq && !s.mgnt;
        lock_s = sel;
        return e;
    endfunction

    task automatic step(input stim_t s);
        rst              = s.rst;
        bus.instr_req_i  = s.ireq;
        bus.instr_addr_i = s.iaddr;
        bus.data_req_i   = s.dreq;
        bus.data_we_i    = s.dwe;
        bus.data_be_i    = s.dbe;
        bus.data_addr_i  = s.daddr;
        bus.data_wdata_i = s.dwdata;
        bus.mem_gnt_i    = s.mgnt;
        bus.mem_rvalid_i = s.mrv;
        bus.mem_rdata_i  = s.mrdata;
        exp_q.push_back(model_eval(s));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle_stim();
        s.rst = 1'b1;
        step(s);
        step(s);
    endtask

    task automatic drain();
        stim_t s;
        for (int n = 0; n < 8 && pend.size() > 0; n++) begin
            s = idle_stim();
            s.mrv = 1'b1;
            step(s);
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_req", 64'(bus.mem_req_o), 64'(e.mem_req));
                chk("instr_gnt", 64'(bus.instr_gnt_o), 64'(e.igt));
                chk("data_gnt", 64'(bus.data_gnt_o), 64'(e.dgt));
                chk("instr_rvalid", 64'(bus.instr_rvalid_o), 64'(e.irv));
                chk("data_rvalid", 64'(bus.data_rvalid_o), 64'(e.drv));
                chk("outstanding", 64'(outstanding), 64'(e.outst));
                chk("spurious", 64'(spurious), 64'(e.spur));
                if (e.irv) chk("instr_rdata", 64'(bus.instr_rdata_o), 64'(e.rdata));
                if (e.drv) chk("data_rdata", 64'(bus.data_rdata_o), 64'(e.rdata));
                if (e.mem_req) begin
                    chk("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    chk("mem_we", 64'(bus.mem_we_o), 64'(e.we));
                    chk("mem_be", 64'(bus.mem_be_o), 64'(e.be));
                    chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.instr_req_i = 0; bus.instr_addr_i = '0;
        bus.data_req_i = 0; bus.data_we_i = 0; bus.data_be_i = '0;
        bus.data_addr_i = '0; bus.data_wdata_i = '0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
        last_g = 0; lock_v = 0; lock_s = 0; spur_m = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single instruction fetch and its response.
        s = idle_stim(); s.ireq = 1; s.iaddr = 32'h0000_0080; s.mgnt = 1; step(s);
        s = idle_stim(); s.mrv = 1; s.mrdata = 32'h000F_A103; step(s);
        s = idle_stim(); step(s);

        // Continuous contention: data first, then alternating.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s = idle_stim(); s.ireq = 1; s.dreq = 1; s.dwe = 1; s.mgnt = 1;
            s.mrv = (i > 0); step(s);
        end
        drain();

        // Stalled data request keeps the bus while instr waits.
        do_reset();
        s = idle_stim(); s.ireq = 1; s.dreq = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.mgnt = 1; step(s);
        s.mgnt = 1; s.mrv = 1; step(s);
        drain();

        // Outstanding limit, including a response cycle with a pending request.
        do_reset();
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; step(s);
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; step(s);
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; step(s);
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; s.mrv = 1; step(s);
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; step(s);
        drain();

        // Interleaved responses route back in order.
        do_reset();
        s = idle_stim(); s.ireq = 1; s.mgnt = 1; step(s);
        s = idle_stim(); s.dreq = 1; s.mgnt = 1; step(s);
        s = idle_stim(); s.mrv = 1; s.mrdata = 32'h1111_1111; step(s);
        s = idle_stim(); s.mrv = 1; s.mrdata = 32'h2222_2222; step(s);

        // Response while idle, then reset clears the flag.
        s = idle_stim(); s.mrv = 1; step(s);
        s = idle_stim(); step(s);
        do_reset();
        s = idle_stim(); step(s);

        // Reset with a transaction in flight makes its late response spurious.
        s = idle_stim(); s.dreq = 1; s.mgnt = 1; step(s);
        do_reset();
        s = idle_stim(); s.mrv = 1; step(s);
        s = idle_stim(); step(s);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle_stim();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.ireq = ($urandom_range(0, 9) < 6);
            s.dreq = ($urandom_range(0, 9) < 6);
            s.dwe  = 1'($urandom);
            s.mgnt = ($urandom_range(0, 9) < 6);
            if (pend.size() > 0) s.mrv = 1'($urandom);
            else                 s.mrv = ($urandom_range(0, 99) == 0);
            step(s);
        end
        drain();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
